// File: rtl/alu_pkg.sv
// Shared ALU constants: op encodings, flag bit positions, widths and the buffer entry payload.
package alu_pkg;

    localparam int unsigned W     = 4;
    localparam int unsigned DEPTH = 2;
    localparam int unsigned NFLG  = 4;
    localparam int unsigned CNT_W = 2;

    localparam logic [2:0] OP_PASS = 3'b000;
    localparam logic [2:0] OP_NEG  = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_INC  = 3'b011;
    localparam int unsigned OP_LOGIC_MSB = 2;

    localparam int unsigned FLG_Z = 3;
    localparam int unsigned FLG_N = 2;
    localparam int unsigned FLG_C = 1;
    localparam int unsigned FLG_V = 0;

    // One buffered result: value plus its {Z,N,C,V} flags captured at push time.
    typedef struct packed {
        logic [W-1:0]    r;
        logic [NFLG-1:0] flags;
    } entry_t;

endpackage

// File: rtl/alu_flags.sv
// Combinational result select and Z/N/C/V flag generation for one ALU operation.
module alu_flags
    import alu_pkg::*;
(
    input  logic [2:0]      Op,
    input  logic [W-1:0]    AMod,
    input  logic [W-1:0]    BMod,
    input  logic [W-1:0]    Sum,
    input  logic            Cout,
    input  logic [W-1:0]    L,
    output logic [W-1:0]    R,
    output logic [NFLG-1:0] flags
);

    logic is_logic;
    // Only the logic/arithmetic split matters here; the adder already applied the low op bits.
    logic unused_op_low;

    assign is_logic      = Op[OP_LOGIC_MSB];
    assign unused_op_low = ^Op[1:0];

    // Pick logic or adder result and derive flags; carry/overflow are meaningless for logic ops.
    always_comb begin
        R            = is_logic ? L : Sum;
        flags        = '0;
        flags[FLG_Z] = (R == '0);
        flags[FLG_N] = R[W-1];
        flags[FLG_C] = !is_logic && Cout;
        flags[FLG_V] = !is_logic && (AMod[W-1] == BMod[W-1]) && (Sum[W-1] != AMod[W-1]);
    end

endmodule

// File: rtl/alu_postprocess.sv
// ALU result stage: flag generation, 2-entry output FIFO with valid/ready, sticky overflow.
module alu_postprocess
    import alu_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      Op,
    input  logic [W-1:0]    AMod,
    input  logic [W-1:0]    BMod,
    input  logic [W-1:0]    Sum,
    input  logic            Cout,
    input  logic [W-1:0]    L,
    input  logic            clr_ovf,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [W-1:0]    R,
    output logic [NFLG-1:0] flags,
    output logic            ovf_sticky
);

    entry_t             new_entry;
    entry_t             mem_q [DEPTH];
    entry_t             mem_d [DEPTH];
    entry_t             out_q;
    entry_t             out_d;
    logic               wr_ptr_q, wr_ptr_d;
    logic               rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               out_valid_q, out_valid_d;
    logic               in_ready_q, in_ready_d;
    logic               ovf_q, ovf_d;
    logic               push;
    logic               pop;

    alu_flags u_flags (
        .Op    (Op),
        .AMod  (AMod),
        .BMod  (BMod),
        .Sum   (Sum),
        .Cout  (Cout),
        .L     (L),
        .R     (new_entry.r),
        .flags (new_entry.flags)
    );

    assign push = in_valid && in_ready_q;
    assign pop  = out_valid_q && out_ready;

    // Next FIFO state; the output register tracks the post-update head and holds after draining.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;

        if (push) begin
            mem_d[wr_ptr_q] = new_entry;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end

        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        out_valid_d = (count_d != '0);
        in_ready_d  = (count_d < CNT_W'(DEPTH));
        out_d       = out_valid_d ? mem_d[rd_ptr_d] : out_q;

        // A V=1 push takes priority over a simultaneous clear.
        if (push && new_entry.flags[FLG_V]) begin
            ovf_d = 1'b1;
        end else if (clr_ovf) begin
            ovf_d = 1'b0;
        end
    end

    // State registers with asynchronous reset to an empty buffer and zeroed outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            out_q       <= '0;
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            count_q     <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            ovf_q       <= 1'b0;
        end else begin
            mem_q       <= mem_d;
            out_q       <= out_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
            ovf_q       <= ovf_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign R          = out_q.r;
    assign flags      = out_q.flags;
    assign ovf_sticky = ovf_q;

endmodule

// File: tb/tb_alu_postprocess.sv
// Directed bench for alu_postprocess: vector table plus backpressure, sticky and reset sequences.
module tb_alu_postprocess;

    logic       clk;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] Op;
    logic [3:0] AMod;
    logic [3:0] BMod;
    logic [3:0] Sum;
    logic       Cout;
    logic [3:0] L;
    logic       clr_ovf;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] R;
    logic [3:0] flags;
    logic       ovf_sticky;

    int checks;
    int errors;

    typedef struct {
        logic [2:0] op;
        logic [3:0] amod;
        logic [3:0] bmod;
        logic [3:0] sum;
        logic       cout;
        logic [3:0] l;
        logic [3:0] exp_r;
        logic [3:0] exp_flags;   // {Z,N,C,V}
    } vec_t;

    localparam int NV = 9;
    vec_t vecs [NV];
    logic exp_ovf;

    alu_postprocess dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .Op         (Op),
        .AMod       (AMod),
        .BMod       (BMod),
        .Sum        (Sum),
        .Cout       (Cout),
        .L          (L),
        .clr_ovf    (clr_ovf),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .R          (R),
        .flags      (flags),
        .ovf_sticky (ovf_sticky)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input vec_t v);
        Op   = v.op;
        AMod = v.amod;
        BMod = v.bmod;
        Sum  = v.sum;
        Cout = v.cout;
        L    = v.l;
    endtask

    initial begin
        checks = 0;
        errors = 0;

        //          op      amod     bmod     sum      c     l        r        ZNCV
        vecs[0] = '{3'b010, 4'b0111, 4'b0001, 4'b1000, 1'b0, 4'b0000, 4'b1000, 4'b0101};
        vecs[1] = '{3'b001, 4'b0001, 4'b1010, 4'b1011, 1'b0, 4'b0000, 4'b1011, 4'b0100};
        vecs[2] = '{3'b001, 4'b0001, 4'b1111, 4'b0000, 1'b1, 4'b0000, 4'b0000, 4'b1010};
        vecs[3] = '{3'b100, 4'b0111, 4'b0111, 4'b1111, 1'b1, 4'b0000, 4'b0000, 4'b1000};
        vecs[4] = '{3'b000, 4'b0000, 4'b1001, 4'b1001, 1'b0, 4'b0000, 4'b1001, 4'b0100};
        vecs[5] = '{3'b011, 4'b0001, 4'b1111, 4'b0000, 1'b1, 4'b0000, 4'b0000, 4'b1010};
        vecs[6] = '{3'b010, 4'b1000, 4'b1000, 4'b0000, 1'b1, 4'b0000, 4'b0000, 4'b1011};
        vecs[7] = '{3'b111, 4'b0000, 4'b0000, 4'b0000, 1'b1, 4'b1010, 4'b1010, 4'b0100};
        vecs[8] = '{3'b010, 4'b0011, 4'b0100, 4'b0111, 1'b0, 4'b0000, 4'b0111, 4'b0000};

        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        clr_ovf   = 1'b0;
        drive(vecs[0]);
        exp_ovf   = 1'b0;

        // Reset state
        #12;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_R", 32'(R), 32'd0);
        chk("rst_flags", 32'(flags), 32'd0);
        chk("rst_ovf", 32'(ovf_sticky), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Vector table: push one entry, check head one cycle later, let it drain
        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            drive(vecs[i]);
            in_valid = 1'b1;
            @(posedge clk);
            #1;
            exp_ovf = exp_ovf | vecs[i].exp_flags[0];
            chk($sformatf("vec%0d_valid", i), 32'(out_valid), 32'd1);
            chk($sformatf("vec%0d_R", i), 32'(R), 32'(vecs[i].exp_r));
            chk($sformatf("vec%0d_flags", i), 32'(flags), 32'(vecs[i].exp_flags));
            chk($sformatf("vec%0d_ovf", i), 32'(ovf_sticky), 32'(exp_ovf));
            @(negedge clk);
            in_valid = 1'b0;
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_drained", i), 32'(out_valid), 32'd0);
            chk($sformatf("vec%0d_hold", i), 32'(R), 32'(vecs[i].exp_r));
        end

        // Backpressure: fill both entries, third waits, then drain in order
        @(negedge clk);
        out_ready = 1'b0;
        drive(vecs[0]);
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        chk("bp1_in_ready", 32'(in_ready), 32'd1);
        chk("bp1_R", 32'(R), 32'(vecs[0].exp_r));
        @(negedge clk);
        drive(vecs[1]);
        @(posedge clk);
        #1;
        chk("bp2_in_ready", 32'(in_ready), 32'd0);
        chk("bp2_R", 32'(R), 32'(vecs[0].exp_r));
        @(negedge clk);
        drive(vecs[2]);
        @(posedge clk);
        #1;
        chk("bp3_in_ready", 32'(in_ready), 32'd0);
        chk("bp3_R", 32'(R), 32'(vecs[0].exp_r));
        chk("bp3_flags", 32'(flags), 32'(vecs[0].exp_flags));
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp4_R", 32'(R), 32'(vecs[1].exp_r));
        chk("bp4_flags", 32'(flags), 32'(vecs[1].exp_flags));
        chk("bp4_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        chk("bp5_R", 32'(R), 32'(vecs[2].exp_r));
        chk("bp5_flags", 32'(flags), 32'(vecs[2].exp_flags));
        chk("bp5_valid", 32'(out_valid), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("bp6_valid", 32'(out_valid), 32'd0);
        chk("bp6_hold_flags", 32'(flags), 32'(vecs[2].exp_flags));

        // Sticky overflow: clear, set-wins-over-clear, clear again
        @(negedge clk);
        clr_ovf = 1'b1;
        @(posedge clk);
        #1;
        chk("ovf_clr", 32'(ovf_sticky), 32'd0);
        @(negedge clk);
        drive(vecs[6]);
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        chk("ovf_set_wins", 32'(ovf_sticky), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("ovf_clr_again", 32'(ovf_sticky), 32'd0);
        @(negedge clk);
        clr_ovf = 1'b0;

        // Reset with two entries buffered takes effect before the next edge
        out_ready = 1'b0;
        drive(vecs[0]);
        in_valid = 1'b1;
        @(negedge clk);
        drive(vecs[7]);
        @(posedge clk);
        #1;
        chk("mr_full", 32'(in_ready), 32'd0);
        chk("mr_ovf_pre", 32'(ovf_sticky), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        reset = 1'b1;
        #1;
        chk("mr_out_valid", 32'(out_valid), 32'd0);
        chk("mr_in_ready", 32'(in_ready), 32'd1);
        chk("mr_R", 32'(R), 32'd0);
        chk("mr_flags", 32'(flags), 32'd0);
        chk("mr_ovf", 32'(ovf_sticky), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("mr_post_valid", 32'(out_valid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
